// File: rtl/proc_gen_if.sv
// proc_gen_if: groups the processor's run control, instruction/data input,
// read-back select and status/bus outputs into one bundle.
//   master : the instruction/data source and observer (drives Run, DIN, RegSel)
//   slave  : the processor core (drives Done, BusWires, RegOut, Zflag, Halted)
interface proc_gen_if #(
    parameter int DATAWIDTH = 9,
    parameter int REG_BITS  = 3
);
    logic                 Run;
    logic [DATAWIDTH-1:0] DIN;
    logic [REG_BITS-1:0]  RegSel;
    logic                 Done;
    logic [DATAWIDTH-1:0] BusWires;
    logic [DATAWIDTH-1:0] RegOut;
    logic                 Zflag;
    logic                 Halted;

    modport master (
        output Run, DIN, RegSel,
        input  Done, BusWires, RegOut, Zflag, Halted
    );

    modport slave (
        input  Run, DIN, RegSel,
        output Done, BusWires, RegOut, Zflag, Halted
    );
endinterface

// File: rtl/proc_gen.sv
// proc_gen: parametrised multicycle bus processor.
//   Clock     : rising-edge system clock
//   Reset     : asynchronous active-high reset, clears all state
//   pbus      : proc_gen_if slave -- Run/DIN/RegSel in;
//               Done (comb), BusWires, RegOut (comb read-back), Zflag, Halted out
// Instruction word (low 3+2*REG_BITS bits of DIN): {op[2:0], X, Y}.
// mv/mvi/mvnz/halt take 2 cycles (fetch + execute), ALU ops take 4.
module proc_gen #(
    parameter int DATAWIDTH = 9,
    parameter int REG_BITS  = 3
) (
    input  logic     Clock,
    input  logic     Reset,
    proc_gen_if.slave pbus
);
    localparam int IW      = 3 + 2 * REG_BITS;
    localparam int REG_NUM = 2 ** REG_BITS;

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ, OP_AND, OP_XOR, OP_HALT
    } op_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_REG, SRC_G, SRC_DIN} src_t;

    logic [DATAWIDTH-1:0] r_regs [REG_NUM];
    logic [DATAWIDTH-1:0] r_a;
    logic [DATAWIDTH-1:0] r_g;
    logic [IW-1:0]        r_ir;
    tstep_t               r_tstep;
    logic                 r_zflag;
    logic                 r_halted;

    tstep_t               w_tstep_next;
    op_t                  w_op;
    logic [REG_BITS-1:0]  w_x;
    logic [REG_BITS-1:0]  w_y;
    src_t                 w_src;
    logic [REG_BITS-1:0]  w_src_idx;
    logic                 w_done;
    logic                 w_ir_in;
    logic                 w_a_in;
    logic                 w_g_in;
    logic                 w_rx_in;
    logic                 w_halt_set;
    logic [DATAWIDTH-1:0] w_bus;
    logic [DATAWIDTH-1:0] w_alu;

    assign w_op = op_t'(r_ir[IW-1 -: 3]);
    assign w_x  = r_ir[2*REG_BITS-1 -: REG_BITS];
    assign w_y  = r_ir[REG_BITS-1:0];

    // NOTE: every signal written here gets a default first, so no path
    // through the case statements leaves a value held (no latches).
    always_comb begin
        w_tstep_next = T0;
        w_src        = SRC_NONE;
        w_src_idx    = '0;
        w_done       = 1'b0;
        w_ir_in      = 1'b0;
        w_a_in       = 1'b0;
        w_g_in       = 1'b0;
        w_rx_in      = 1'b0;
        w_halt_set   = 1'b0;
        if (!r_halted) begin
            unique case (r_tstep)
                T0: begin
                    // IR reloads on every T0 cycle, even while waiting for Run.
                    w_ir_in      = 1'b1;
                    w_tstep_next = pbus.Run ? T1 : T0;
                end
                T1: begin
                    unique case (w_op)
                        OP_MV: begin
                            w_src     = SRC_REG;
                            w_src_idx = w_y;
                            w_rx_in   = 1'b1;
                            w_done    = 1'b1;
                        end
                        OP_MVI: begin
                            w_src   = SRC_DIN;
                            w_rx_in = 1'b1;
                            w_done  = 1'b1;
                        end
                        OP_MVNZ: begin
                            if (!r_zflag) begin
                                w_src     = SRC_REG;
                                w_src_idx = w_y;
                                w_rx_in   = 1'b1;
                            end
                            w_done = 1'b1;
                        end
                        OP_HALT: begin
                            w_halt_set = 1'b1;
                            w_done     = 1'b1;
                        end
                        default: begin
                            // ALU ops: latch first operand R[X] into A.
                            w_src        = SRC_REG;
                            w_src_idx    = w_x;
                            w_a_in       = 1'b1;
                            w_tstep_next = T2;
                        end
                    endcase
                end
                T2: begin
                    w_src        = SRC_REG;
                    w_src_idx    = w_y;
                    w_g_in       = 1'b1;
                    w_tstep_next = T3;
                end
                T3: begin
                    w_src   = SRC_G;
                    w_rx_in = 1'b1;
                    w_done  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_bus = '0;
        unique case (w_src)
            SRC_REG:  w_bus = r_regs[w_src_idx];
            SRC_G:    w_bus = r_g;
            SRC_DIN:  w_bus = pbus.DIN;
            default:  w_bus = '0;
        endcase
    end

    // Only ALU opcodes ever reach T2; carries/borrows drop off the top.
    always_comb begin
        w_alu = '0;
        unique case (w_op)
            OP_SUB:  w_alu = r_a - w_bus;
            OP_AND:  w_alu = r_a & w_bus;
            OP_XOR:  w_alu = r_a ^ w_bus;
            default: w_alu = r_a + w_bus;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_tstep <= T0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            r_tstep <= w_tstep_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            // NOTE: the register file is architecturally visible after reset
            // (all zeros), so it is reset here rather than left as a RAM.
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
            r_a      <= '0;
            r_g      <= '0;
            r_ir     <= '0;
            r_zflag  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            if (w_ir_in)    r_ir         <= pbus.DIN[IW-1:0];
            if (w_a_in)     r_a          <= w_bus;
            if (w_rx_in)    r_regs[w_x]  <= w_bus;
            if (w_halt_set) r_halted     <= 1'b1;
            if (w_g_in) begin
                r_g     <= w_alu;
                r_zflag <= (w_alu == '0);
            end
        end
    end

    assign pbus.Done     = w_done;
    assign pbus.BusWires = w_bus;
    assign pbus.RegOut   = r_regs[pbus.RegSel];
    assign pbus.Zflag    = r_zflag;
    assign pbus.Halted   = r_halted;
endmodule

// File: tb/tb_proc_gen.sv
// tb_proc_gen: directed self-checking bench for proc_gen (DATAWIDTH=9, REG_BITS=3).
module tb_proc_gen;
    logic Clock;
    logic Reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    proc_gen_if #(.DATAWIDTH(9), .REG_BITS(3)) pif ();

    proc_gen #(.DATAWIDTH(9), .REG_BITS(3)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .pbus  (pif.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then step 1 ns past the edge before sampling/driving.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_reg(input int idx, input logic [8:0] exp, input string tag);
        pif.RegSel = idx[2:0];
        #1;
        check(tag, {23'd0, pif.RegOut}, {23'd0, exp});
    endtask

    // Issue one instruction with Run high. imm is driven during T1; Done must
    // stay low until the last of the given number of cycles.
    task automatic run_instr(input logic [8:0] instr, input logic [8:0] imm,
                             input int cycles, input string tag);
        pif.Run = 1'b1;
        pif.DIN = instr;
        #1;
        check({tag, " done@T0"}, {31'd0, pif.Done}, 32'd0);
        tick();
        pif.DIN = imm;
        for (int k = 1; k < cycles; k++) begin
            #1;
            check($sformatf("%s done@T%0d", tag, k), {31'd0, pif.Done},
                  {31'd0, (k == cycles - 1)});
            tick();
        end
    endtask

    initial begin
        Reset      = 1'b1;
        pif.Run    = 1'b0;
        pif.DIN    = '0;
        pif.RegSel = '0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        #1;
        check("reset done",   {31'd0, pif.Done},     32'd0);
        check("reset bus",    {23'd0, pif.BusWires}, 32'd0);
        check("reset zflag",  {31'd0, pif.Zflag},    32'd0);
        check("reset halted", {31'd0, pif.Halted},   32'd0);
        check_reg(0, 9'h000, "reset R0");

        // Reset pulsed during T2 of an add.
        run_instr(9'h040, 9'd5, 2, "pre mvi R0");
        run_instr(9'h048, 9'd3, 2, "pre mvi R1");
        pif.DIN = 9'h081;
        tick();
        tick();
        check("mid-sum in T2", {30'd0, dut.r_tstep}, 32'd2);
        pif.Run = 1'b0;
        Reset = 1'b1;
        #1;
        check("async tstep", {30'd0, dut.r_tstep}, 32'd0);
        #1 Reset = 1'b0;
        tick();
        check("post-reset done",  {31'd0, pif.Done},  32'd0);
        check("post-reset zflag", {31'd0, pif.Zflag}, 32'd0);
        check("post-reset tstep", {30'd0, dut.r_tstep}, 32'd0);
        check_reg(0, 9'h000, "post-reset R0");
        check_reg(1, 9'h000, "post-reset R1");

        // mvi and read-back.
        run_instr(9'h040, 9'd5, 2, "mvi R0");
        check_reg(0, 9'd5, "mvi R0");
        run_instr(9'h048, 9'd3, 2, "mvi R1");
        check_reg(1, 9'd3, "mvi R1 readback");

        // add R0,R1 with explicit bus checks per step.
        pif.Run = 1'b1;
        pif.DIN = 9'h081;
        #1;
        check("add T0 bus", {23'd0, pif.BusWires}, 32'd0);
        tick();
        check("add T1 bus", {23'd0, pif.BusWires}, 32'd5);
        tick();
        check("add T2 bus", {23'd0, pif.BusWires}, 32'd3);
        check("add T2 done", {31'd0, pif.Done}, 32'd0);
        tick();
        check("add T3 bus", {23'd0, pif.BusWires}, 32'd8);
        check("add T3 done", {31'd0, pif.Done}, 32'd1);
        tick();
        check_reg(0, 9'd8, "add R0");
        check("add zflag", {31'd0, pif.Zflag}, 32'd0);

        run_instr(9'h0C0, 9'd0, 4, "sub R0,R0");
        check_reg(0, 9'd0, "sub R0,R0");
        check("sub zflag", {31'd0, pif.Zflag}, 32'd1);

        // Wrap-around; mvi must leave Zflag alone.
        run_instr(9'h050, 9'h1FF, 2, "mvi R2");
        run_instr(9'h058, 9'h001, 2, "mvi R3");
        check("mvi keeps zflag", {31'd0, pif.Zflag}, 32'd1);
        run_instr(9'h093, 9'd0, 4, "add R2,R3");
        check_reg(2, 9'h000, "add wrap R2");
        check("add wrap zflag", {31'd0, pif.Zflag}, 32'd1);

        // mvnz with Zflag = 1: no write.
        run_instr(9'h121, 9'd0, 2, "mvnz z1");
        check_reg(4, 9'h000, "mvnz z1 R4");
        check("mvnz keeps zflag", {31'd0, pif.Zflag}, 32'd1);

        run_instr(9'h0D3, 9'd0, 4, "sub R2,R3");
        check_reg(2, 9'h1FF, "sub borrow R2");
        check("sub borrow zflag", {31'd0, pif.Zflag}, 32'd0);

        run_instr(9'h121, 9'd0, 2, "mvnz z0");
        check_reg(4, 9'd3, "mvnz z0 R4");

        // X == Y doubles the register.
        run_instr(9'h09B, 9'd0, 4, "add R3,R3");
        check_reg(3, 9'd2, "add R3,R3");

        // Bitwise ops.
        run_instr(9'h068, 9'h0F0, 2, "mvi R5");
        run_instr(9'h070, 9'h0FF, 2, "mvi R6");
        run_instr(9'h16E, 9'd0, 4, "and R5,R6");
        check_reg(5, 9'h0F0, "and R5");
        run_instr(9'h1AE, 9'd0, 4, "xor R5,R6");
        check_reg(5, 9'h00F, "xor R5");
        check("xor zflag", {31'd0, pif.Zflag}, 32'd0);
        run_instr(9'h1B6, 9'd0, 4, "xor R6,R6");
        check_reg(6, 9'h000, "xor R6,R6");
        check("xor zero zflag", {31'd0, pif.Zflag}, 32'd1);

        // Run dropped mid-instruction: add R5,R3 still completes.
        pif.Run = 1'b1;
        pif.DIN = 9'h0AB;
        tick();
        pif.Run = 1'b0;
        tick();
        tick();
        check("run-drop done", {31'd0, pif.Done}, 32'd1);
        tick();
        check_reg(5, 9'h011, "run-drop R5");

        // Run low at T0: Tstep holds, nothing written.
        pif.DIN = 9'h040;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("run low tstep %0d", k), {30'd0, dut.r_tstep}, 32'd0);
            check($sformatf("run low done %0d", k), {31'd0, pif.Done}, 32'd0);
        end
        check_reg(0, 9'h000, "run low R0");

        // halt.
        run_instr(9'h1C0, 9'd0, 2, "halt");
        check("halted", {31'd0, pif.Halted}, 32'd1);
        pif.Run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pif.DIN = (k % 2 == 0) ? 9'h040 : 9'h1FF;
            #1;
            check($sformatf("halted done %0d", k), {31'd0, pif.Done}, 32'd0);
            check($sformatf("halted tstep %0d", k), {30'd0, dut.r_tstep}, 32'd0);
            tick();
        end
        check("still halted", {31'd0, pif.Halted}, 32'd1);
        check_reg(0, 9'h000, "halt R0");
        check_reg(1, 9'h003, "halt R1");
        check_reg(2, 9'h1FF, "halt R2");
        check_reg(3, 9'h002, "halt R3");
        check_reg(4, 9'h003, "halt R4");
        check_reg(5, 9'h011, "halt R5");
        check_reg(6, 9'h000, "halt R6");

        pif.Run = 1'b0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        check("reset clears halted", {31'd0, pif.Halted}, 32'd0);
        check_reg(2, 9'h000, "reset clears R2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/proc_gen.md
Name: proc_gen

Overview:
- Parametrised next-generation multicycle bus processor.
- Register file depth, data width and register-field width are parameters.
- The opcode field widens to 3 bits and adds four instructions: mvnz, and, xor, halt.
- A zero flag, a halted status and a register read-back port replace external probing; the block sits between instruction/data source DIN and the shared BusWires.

Parameters:
- DATAWIDTH, 9, width of DIN, BusWires, registers, A, G; must be >= 3+2*REG_BITS
- REG_BITS, 3, register index field width; REG_NUM = 2**REG_BITS general registers

Ports:
- Clock  input  1  single system clock, all state rising-edge
- Reset  input  1  asynchronous, active-high; clears all state
- Run  input  1  start/continue execution; sampled at Tstep 0
- DIN  input  DATAWIDTH  instruction word (Tstep 0) or immediate (mvi Tstep 1)
- RegSel  input  REG_BITS  register index for read-back
- Done  output  1  combinational; high in final step of each instruction
- BusWires  output  DATAWIDTH  shared bus value
- RegOut  output  DATAWIDTH  contents of R[RegSel], combinational
- Zflag  output  1  registered; 1 when last ALU result written to G was zero
- Halted  output  1  registered; high after halt executed

Behaviour:
- Reset: R[*], A, G, IR, Tstep = 0; Zflag = 0; Halted = 0; Done = 0; BusWires = 0.
- IR is 3+2*REG_BITS bits, taken from DIN low bits:
  - op = IR[top 3 bits]
  - X = next REG_BITS bits
  - Y = low REG_BITS bits
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D
  - 010 add
  - 011 sub
  - 100 mvnz Rx,Ry (move if Zflag = 0)
  - 101 and
  - 110 xor
  - 111 halt
- Tstep: 2-bit counter, 0..3. Cleared when Done = 1, or when Tstep = 0 and Run = 0, or when Halted = 1; otherwise increments.
- T0: IRin = 1 (IR <= DIN) unless Halted; no bus driver.
- T1 behaviour by opcode:
  - mv: bus = R[Y], R[X] load, Done.
  - mvi: bus = DIN, R[X] load, Done. The immediate must be on DIN during T1.
  - mvnz: if Zflag = 0, bus = R[Y] and R[X] loads; else no write. Done either way.
  - add/sub/and/xor: bus = R[X], A load.
  - halt: Done, Halted <= 1.
- T2 (ALU ops only): bus = R[Y]; G <= A op Bus; Zflag <= (ALU result == 0).
- T3 (ALU ops only): bus = G, R[X] load, Done.
- Latencies:
  - mv, mvi, mvnz, halt: 2 cycles including fetch.
  - ALU ops: 4 cycles.
- Arithmetic is modulo 2**DATAWIDTH; carry and borrow are discarded. and/xor are bitwise.
- Zflag updates only on G load; mv, mvi and mvnz leave it unchanged.
- Bus mux: exactly one source enabled per cycle (R[i], G or DIN); when none is enabled, BusWires = 0.
- Run dropped mid-instruction has no effect; the instruction completes, and the next fetch waits in T0 until Run = 1. IR still reloads every T0 cycle while waiting.
- Halted: Tstep pinned at 0, IR frozen, no register writes, Done = 0. Only Reset clears it.
- Reset asserted mid-instruction aborts immediately and asynchronously; no partial write survives the edge.
- Register write when X == Y (e.g. add R1,R1): A captures the old value in T1 and R[Y] is read in T2, so the result is 2*R1 mod 2**DATAWIDTH.
- RegOut is a pure read-back and never affects the bus.

Test Plan:
- Reset mid-sum: pulse Reset during T2 of an add → all registers 0, Tstep 0, Zflag 0, Done 0 on the next cycle.
- mvi and read-back: Run = 1, DIN = 0x040 (mvi R0) then 5 → Done in 2nd cycle, R0 = 5. Then mvi R1,#3 and RegSel = 1 → RegOut = 3.
- add then sub:
  - add R0,R1 (0x081) with R0 = 5, R1 = 3 → Done at T3, R0 = 8, Zflag = 0.
  - sub R0,R0 (0x0C0) → R0 = 0, Zflag = 1.
- Wrap-around: R2 = 0x1FF, R3 = 1, add R2,R3 → R2 = 0, Zflag = 1. Then sub R2,R3 → R2 = 0x1FF, Zflag = 0.
- mvnz:
  - Zflag = 1, mvnz R4,R1 (0x121) → R4 unchanged, Done asserted.
  - After an ALU op clears Zflag, repeat → R4 = R1.
- Bitwise, halt, Run low:
  - R5 = 0x0F0, R6 = 0x0FF: and R5,R6 → 0x0F0; xor R5,R6 → 0x00F.
  - halt (0x1C0) → Halted = 1; further DIN words and Run ignored for 10 cycles; registers unchanged until Reset.
  - Run = 0 at T0 → Tstep holds 0.
